// File: rtl/mem_rmw_arbiter_pkg.sv
// Shared types and constants for the two-requester read-modify-write memory front end.
package mem_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned N_REQ      = 2;

    // Mask value that writes every bit of a word
    localparam logic [DEF_DATA_W-1:0] MASK_ALL_ONES = '1;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_RD  = 3'd1,
        S_WR  = 3'd2,
        S_CAP = 3'd3,
        S_RSP = 3'd4
    } state_e;

    // Requester index (two requesters)
    typedef logic req_id_t;

endpackage

// File: rtl/mem_rmw_arbiter_if.sv
// Requester-side bus of mem_rmw_arbiter: packed per-requester requests plus responses.
interface mem_rmw_arbiter_if
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_wr;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ*DATA_W-1:0] req_mask;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;

    // Requester side
    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_mask,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_mask,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_rmw_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; priority flips away from the requester last granted.
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    // Requester holding priority when both request; reset favours requester 0
    req_id_t ptr_q;

    // Grant: lone requester wins, otherwise the prioritised one
    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // Pointer moves only when a grant is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (advance_i) begin
            ptr_q <= req_id_t'(grant_o[0]);
        end
    end

endmodule

// File: rtl/mem_rmw_arbiter.sv
// Round-robin arbiter and read-modify-write sequencer in front of a bit-masked
// single-port memory. Masked writes become read-merge-full-write so unmasked
// bits survive; reads pass through.
// Optional: MEM_RMW_FULL_MASK_BYPASS_EN lets all-ones-mask writes skip the read.
module mem_rmw_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_rmw_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_o,
    output logic              mem_c_en_o,
    output logic [DATA_W-1:0] mem_bit_mask_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    input  logic [DATA_W-1:0] mem_rd_data_i
);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] mask;
    } op_t;

    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    state_e            state_q, state_d;
    op_t               op_q, in_op;
    req_id_t           id_q, win_id;
    logic [1:0]        grant;
    logic              hs;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_c_en_q, mem_wr_q;
    logic [DATA_W-1:0] mem_bit_mask_q, wr_hold_q, merged_c, rdata_q;
    logic [1:0]        rsp_valid_q;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (bus.req_valid),
        .advance_i (hs),
        .grant_o   (grant)
    );

    assign win_id = req_id_t'(grant[1]);

    // Select the winning requester's payload
    always_comb begin
        in_op.wr = bus.req_wr[win_id];
        if (win_id) begin
            in_op.addr  = bus.req_addr[ADDR_W +: ADDR_W];
            in_op.wdata = bus.req_wdata[DATA_W +: DATA_W];
            in_op.mask  = bus.req_mask[DATA_W +: DATA_W];
        end else begin
            in_op.addr  = bus.req_addr[0 +: ADDR_W];
            in_op.wdata = bus.req_wdata[0 +: DATA_W];
            in_op.mask  = bus.req_mask[0 +: DATA_W];
        end
    end

    // Old word (valid in S_WR) merged with the masked new bits
    assign merged_c = (mem_rd_data_i & ~op_q.mask) | (op_q.wdata & op_q.mask);

    // Next state, handshake and combinational ready
    always_comb begin
        state_d       = state_q;
        hs            = 1'b0;
        bus.req_ready = 2'b00;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = grant;
                if (|grant) begin
                    hs = 1'b1;
`ifdef MEM_RMW_FULL_MASK_BYPASS_EN
                    if (in_op.wr && (in_op.mask == ALL_ONES)) state_d = S_WR;
                    else                                       state_d = S_RD;
`else
                    state_d = S_RD;
`endif
                end
            end
            S_RD:    state_d = op_q.wr ? S_WR : S_CAP;
            S_WR:    state_d = S_RSP;
            S_CAP:   state_d = S_RSP;
            S_RSP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request latch taken at handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            id_q <= 1'b0;
        end else if (hs) begin
            op_q <= in_op;
            id_q <= win_id;
        end
    end

    // Memory control outputs registered from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_c_en_q     <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_bit_mask_q <= '0;
            mem_addr_q     <= '0;
        end else begin
            mem_c_en_q     <= (state_d == S_RD) || (state_d == S_WR);
            mem_wr_q       <= (state_d == S_WR);
            mem_bit_mask_q <= (state_d == S_WR) ? ALL_ONES : '0;
            if (hs) mem_addr_q <= in_op.addr;
        end
    end

    // Response pulse to the served requester and captured read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 2'b00;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= (state_d == S_RSP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
            if (state_q == S_CAP) rdata_q <= mem_rd_data_i;
        end
    end

    // Merged word must follow mem_rd_data within S_WR; hold it afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wr_hold_q <= '0;
        else if (state_q == S_WR)  wr_hold_q <= merged_c;
    end

    assign mem_wr_data_o  = (state_q == S_WR) ? merged_c : wr_hold_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wr_o       = mem_wr_q;
    assign mem_c_en_o     = mem_c_en_q;
    assign mem_bit_mask_o = mem_bit_mask_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_rmw_arbiter.sv
// Bench for mem_rmw_arbiter: behavioural bit-masked memory, shadow word model,
// directed scenarios followed by random traffic.
module tb_mem_rmw_arbiter;
    import mem_ctrl_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
`ifdef MEM_RMW_FULL_MASK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] mem_addr;
    logic          mem_wr, mem_c_en;
    logic [DW-1:0] mem_bit_mask, mem_wr_data, mem_rd_data;

    mem_rmw_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_rmw_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .mem_addr_o     (mem_addr),
        .mem_wr_o       (mem_wr),
        .mem_c_en_o     (mem_c_en),
        .mem_bit_mask_o (mem_bit_mask),
        .mem_wr_data_o  (mem_wr_data),
        .mem_rd_data_i  (mem_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: stores wr_data & bit_mask, 1-cycle registered read
    logic [DW-1:0] mem [256];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_c_en) begin
            if (mem_wr) mem[mem_addr] <= mem_wr_data & mem_bit_mask;
            else        mem_rd_data   <= mem[mem_addr];
        end
    end

    // Reference contents and arbitration history
    logic [DW-1:0] shadow [256];
    int            last_served;
    int            tests;
    int            fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},   64'(bus.req_ready), 0);
        chk({tag, "_rspv"},    64'(bus.rsp_valid), 0);
        chk({tag, "_rdata"},   64'(bus.rsp_rdata), 0);
        chk({tag, "_wr"},      64'(mem_wr), 0);
        chk({tag, "_cen"},     64'(mem_c_en), 0);
        chk({tag, "_addr"},    64'(mem_addr), 0);
        chk({tag, "_wdata"},   64'(mem_wr_data), 0);
        chk({tag, "_bitmask"}, 64'(mem_bit_mask), 0);
    endtask

    task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] m);
        bus.req_wr[r]              = wr;
        bus.req_addr[r*AW +: AW]   = a;
        bus.req_wdata[r*DW +: DW]  = wd;
        bus.req_mask[r*DW +: DW]   = m;
    endtask

    // Issue one operation from requester r (called at a negedge) and check it end to end
    task automatic run_op(input string tag, input int r, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] m,
                          output logic [DW-1:0] rdata);
        logic [DW-1:0] exp_d;
        int  exp_lat, exp_cen, lat, n_cen;
        bit  rdy, got, seen_rd, seen_wr;
        exp_d   = wr ? ((shadow[a] & ~m) | (wd & m)) : shadow[a];
        exp_lat = (wr && BYPASS && (m == 32'hFFFF_FFFF)) ? 2 : 3;
        exp_cen = wr ? exp_lat - 1 : 1;
        rdata   = '0;
        rdy = 0; got = 0; seen_rd = 0; seen_wr = 0; lat = 0; n_cen = 0;
        set_req(r, wr, a, wd, m);
        bus.req_valid[r] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready[r]) begin
                rdy = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_ready"}, 64'(rdy), 1);
        if (!rdy) begin
            bus.req_valid[r] = 1'b0;
            return;
        end
        chk({tag, "_ready_vec"}, 64'(bus.req_ready), 64'(1 << r));
        @(posedge clk);
        last_served = r;
        @(negedge clk);
        bus.req_valid[r] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_c_en) n_cen++;
            if (mem_c_en && !mem_wr) begin
                seen_rd = 1;
                chk({tag, "_rd_addr"}, 64'(mem_addr), 64'(a));
            end
            if (mem_c_en && mem_wr) begin
                seen_wr = 1;
                chk({tag, "_wr_addr"}, 64'(mem_addr), 64'(a));
                chk({tag, "_wr_data"}, 64'(mem_wr_data), 64'(exp_d));
                chk({tag, "_wr_mask"}, 64'(mem_bit_mask), 64'(32'hFFFF_FFFF));
            end
            if (bus.rsp_valid != 2'b00) begin
                got   = 1;
                lat   = c;
                rdata = bus.rsp_rdata;
                chk({tag, "_rsp_vec"}, 64'(bus.rsp_valid), 64'(1 << r));
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_rsp_seen"}, 64'(got), 1);
        chk({tag, "_latency"},  64'(lat), 64'(exp_lat));
        chk({tag, "_cen_cyc"},  64'(n_cen), 64'(exp_cen));
        chk({tag, "_rd_issued"}, 64'(seen_rd), 64'(exp_lat == 3));
        chk({tag, "_wr_issued"}, 64'(seen_wr), 64'(wr));
        if (wr) shadow[a] = exp_d;
        else    chk({tag, "_rdata"}, 64'(rdata), 64'(exp_d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] init_v;
        int            g [4];
        int            n, w, cnt, r;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] m, wd;

        tests = 0; fails = 0; last_served = 1;
        rst_n = 1'b0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        bus.req_valid = '0; bus.req_wr = '0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_mask = '0;

        // Preload every word while held in reset
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            case (i)
                8'h10:   init_v = 32'hFFFF_0000;
                8'h20:   init_v = 32'h1111_1111;
                8'hFF:   init_v = 32'hDEAD_BEEF;
                default: init_v = $urandom;
            endcase
            pre_en = 1'b1; pre_addr = AW'(i); pre_data = init_v;
            shadow[i] = init_v;
        end
        @(negedge clk);
        pre_en = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesters valid and held: grants must alternate starting with 0
        set_req(0, 1'b0, 8'h10, '0, '0);
        set_req(1, 1'b0, 8'h11, '0, '0);
        bus.req_valid = 2'b11;
        n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                chk($sformatf("arb_onehot%0d", n), 64'($countones(bus.req_ready)), 1);
                g[n] = int'(bus.req_ready[1]);
                n++;
            end
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        chk("arb_count", 64'(n), 4);
        for (int i = 0; i < 4; i++) begin
            w = (last_served == 0) ? 1 : 0;
            chk($sformatf("arb_grant%0d", i), 64'(g[i]), 64'(w));
            last_served = w;
        end
        repeat (4) @(negedge clk);

        // Partial-mask RMW then readback
        run_op("rmw_wr", 0, 1'b1, 8'h10, 32'h0000_1234, 32'h0000_FFFF, rd);
        run_op("rmw_rd", 1, 1'b0, 8'h10, '0, '0, rd);
        chk("rmw_value", 64'(rd), 64'(32'hFFFF_1234));

        // Zero mask rewrites the word unchanged at the top address
        run_op("m0_wr", 1, 1'b1, 8'hFF, 32'h1234_5678, 32'h0000_0000, rd);
        run_op("m0_rd", 0, 1'b0, 8'hFF, '0, '0, rd);
        chk("m0_value", 64'(rd), 64'(32'hDEAD_BEEF));

        // Read of address 0
        run_op("rd0", 0, 1'b0, 8'h00, '0, '0, rd);

        // Full-mask overwrite
        run_op("full_wr", 1, 1'b1, 8'h40, 32'hA5A5_A5A5, 32'hFFFF_FFFF, rd);
        run_op("full_rd", 0, 1'b0, 8'h40, '0, '0, rd);
        chk("full_value", 64'(rd), 64'(32'hA5A5_A5A5));

        // Valid dropped before any clock edge issues nothing
        @(negedge clk);
        set_req(1, 1'b1, 8'h30, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.req_valid[1] = 1'b1;
        #2;
        bus.req_valid[1] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_c_en) cnt++;
            if (bus.rsp_valid != 2'b00) cnt++;
        end
        chk("drop_valid_idle", 64'(cnt), 0);

        // Random traffic against the shadow model
        for (int i = 0; i < 24; i++) begin
            r  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 8'h00;
                1:       a = 8'hFF;
                default: a = AW'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       m = 32'h0000_0000;
                1:       m = 32'hFFFF_FFFF;
                default: m = $urandom;
            endcase
            wd = $urandom;
            run_op($sformatf("rand%0d", i), r, wr, a, wd, m, rd);
        end

        // Reset during the read phase of a write: nothing committed, no response
        @(negedge clk);
        set_req(0, 1'b1, 8'h20, 32'h0000_0000, 32'hFFFF_0000);
        bus.req_valid[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready[0]) begin
                n = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_ready", 64'(n), 1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_pre_cen", 64'(mem_c_en), 1);
        chk("rst_pre_wr",  64'(mem_wr), 0);
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) cnt++;
            if (mem_c_en) cnt++;
        end
        chk("rst_quiet", 64'(cnt), 0);
        rst_n = 1'b1;
        last_served = 1;
        @(negedge clk);
        run_op("rst_rd", 0, 1'b0, 8'h20, '0, '0, rd);
        chk("rst_value", 64'(rd), 64'(32'h1111_1111));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_rmw_arbiter.md
Name: mem_rmw_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 256x32 bit-masked single-port memory (addr/wr/c_en/bit_mask/wr_data/rd_data, 1-cycle registered read).
- The memory stores wr_data & bit_mask, which clears unmasked bits. This block therefore turns each masked write into a true read-modify-write: unmasked bits are preserved.
- Reads pass through unchanged. Requesters are served round-robin, one operation at a time.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 32, data, mask and read-data width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; at most one bit high.
- req_wr  in  2  1 = masked write, 0 = read.
- req_addr  in  2*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  packed write data.
- req_mask  in  2*DATA_W  packed bit masks; 1 = bit is written.
- rsp_valid  out  2  one-cycle completion pulse to the requester that was served.
- rsp_rdata  out  DATA_W  read data, valid when rsp_valid is high for a read.
- mem_addr  out  ADDR_W  to memory addr.
- mem_wr  out  1  to memory wr.
- mem_c_en  out  1  to memory c_en.
- mem_bit_mask  out  DATA_W  to memory bit_mask.
- mem_wr_data  out  DATA_W  to memory wr_data.
- mem_rd_data  in  DATA_W  from memory rd_data.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; rr pointer = 0, so requester 0 has priority first.
  - req_ready, rsp_valid, mem_wr and mem_c_en are 0.
  - rsp_rdata, mem_addr, mem_wr_data and mem_bit_mask are 0.
  - An in-flight operation is dropped with no response. A write whose S_WR edge has not occurred is not committed.
- States and sequence:
  - IDLE: req_ready is combinational, high only for the arbitration winner. The handshake is valid&ready at edge T.
  - At handshake the block latches op, addr, wdata, mask and requester id, then moves to S_RD.
  - S_RD (T+1): mem_c_en=1, mem_wr=0, mem_addr=latched addr. Next state is S_WR for a write, S_CAP for a read.
  - S_WR (T+2): mem_rd_data holds the old word. Drive:
    - mem_c_en=1, mem_wr=1;
    - mem_bit_mask = all ones;
    - mem_wr_data = (old & ~mask) | (wdata & mask).
    - Next state S_RSP.
  - S_CAP (T+2): mem_c_en=0; rdata_q <= mem_rd_data. Next state S_RSP.
  - S_RSP (T+3): rsp_valid[id]=1 for exactly one cycle; rsp_rdata = rdata_q (reads only; holds its last value after writes). Next state IDLE.
- mem_c_en=0 in every state except S_RD and S_WR. mem_addr and mem_wr_data hold their values when idle.
- Throughput is one operation per 4 cycles. req_ready is 0 outside IDLE.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not served last wins.
  - The pointer updates only on handshake.
- Requesters hold addr/wdata/mask/wr stable while valid && !ready. Dropping valid before ready is allowed and issues nothing.
- Boundary conditions:
  - mask=0: the word is rewritten unchanged.
  - mask=all ones: full overwrite.
  - addr 0 and addr 255 are legal; there is no wrap-around.

Optional Feature:
- Macro: MEM_RMW_FULL_MASK_BYPASS_EN.
- Defined: a write whose mask is all ones skips S_RD. The block goes IDLE -> S_WR (T+1, mem_wr_data = wdata) -> S_RSP (T+2), so rsp_valid arrives at T+2.
- Undefined: every write takes the full RMW path, with rsp_valid at T+3.
- Reads and partial-mask writes are identical either way.

Decomposition:
- Package mem_ctrl_pkg holds:
  - state enum (IDLE, S_RD, S_WR, S_CAP, S_RSP);
  - ADDR_W/DATA_W defaults;
  - the all-ones mask constant;
  - the requester-id type.
- Sub-module rr_arb2: 2-way round-robin arbiter. Inputs req[1:0], advance; outputs grant[1:0] and a last-grant flop with async active-low reset.
- The FSM, request latches and merge logic stay in mem_rmw_arbiter.

Test Plan:
- Preload addr 0x10 = 0xFFFF_0000. Req0 write, wdata=0x0000_1234, mask=0x0000_FFFF:
  - rsp_valid[0] at T+3;
  - a subsequent read of 0x10 returns 0xFFFF_1234.
- Both requesters valid in the same cycle after reset:
  - req0 granted first, req1 on the next IDLE;
  - if both stay valid, grants alternate 0,1,0,1.
- Write mask=0x0000_0000 to addr 0xFF holding 0xDEAD_BEEF -> mem_wr_data=0xDEAD_BEEF in S_WR; a readback is unchanged.
- Read of addr 0x00 -> rsp_rdata equals stored word at T+3; mem_wr stays 0 throughout.
- Assert rst_n low during S_RD of a write to addr 0x20 holding 0x1111_1111:
  - all outputs 0 immediately;
  - no rsp_valid;
  - addr 0x20 still reads 0x1111_1111.
- With MEM_RMW_FULL_MASK_BYPASS_EN, write mask=0xFFFF_FFFF, wdata=0xA5A5_A5A5:
  - no read cycle issued;
  - rsp_valid at T+2;
  - readback 0xA5A5_A5A5.
